// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encodings and FSM state type for the multi-cycle ALU.
// Opcodes 000..011 keep the legacy single-cycle ALU encodings.
package alu_pkg;

    localparam logic [2:0] OP_FWD   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_SHIFT = 3'b110;
    localparam logic [2:0] OP_ROR   = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: purely combinational single-cycle part of the ALU.
// Ports:
//   op     - opcode (only FWD/ADD/AND/OR/SUB produce a value, others give 0)
//   a, b   - operands
//   res    - result, WIDTH bits
//   cy     - carry-out for ADD, no-borrow (a >= b) for SUB, 0 otherwise
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             cy
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    // Opcode decode; SUB is a + ~b + 1 so its carry-out is the no-borrow flag.
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b};
        diff_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        res    = {WIDTH{1'b0}};
        cy     = 1'b0;
        case (op)
            OP_FWD: res = b;
            OP_ADD: begin
                res = sum_s[WIDTH-1:0];
                cy  = sum_s[WIDTH];
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_SUB: begin
                res = diff_s[WIDTH-1:0];
                cy  = diff_s[WIDTH];
            end
            default: begin
                res = {WIDTH{1'b0}};
                cy  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle ALU with START/BUSY/DONE handshake.
// Ports:
//   CLK, RESETN        - rising-edge clock, asynchronous active-low reset
//   START              - request, accepted only while the FSM is idle
//   SELECT             - opcode (see alu_pkg)
//   DATA1, DATA2       - operands A and B, captured when START is accepted
//   RESULT/ZERO/CARRY  - registered result and flags, updated on completion
//   BUSY               - iterative op in progress
//   DONE               - one-cycle completion pulse
// Single-cycle ops complete straight from IDLE. MUL, SHIFT and ROR run in
// EXEC, one bit per cycle; the cycle right after acceptance is the first
// EXEC cycle and BUSY is only raised for the remaining iterations, so BUSY
// covers exactly the cycles strictly between the start and finishing edges.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             CARRY,
    output logic             BUSY,
    output logic             DONE
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_ONE = {{SHW{1'b0}}, 1'b1};
    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

    state_e           state_q, state_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;       // MUL multiplicand
    logic [WIDTH-1:0] sr_q, sr_d;     // shift/rotate value, or MUL low half
    logic [WIDTH-1:0] hi_q, hi_d;     // MUL high half (partial sum)
    logic             dir_q, dir_d;   // 1 = shift right
    logic             cy_q, cy_d;     // last bit shifted/rotated out
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2:0]       core_op_s;
    logic [WIDTH-1:0] core_a_s;
    logic [WIDTH-1:0] core_b_s;
    logic [WIDTH-1:0] core_res_s;
    logic             core_cy_s;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .op  (core_op_s),
        .a   (core_a_s),
        .b   (core_b_s),
        .res (core_res_s),
        .cy  (core_cy_s)
    );

    // Next-state, datapath and output computation for the IDLE/EXEC FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        sr_d     = sr_q;
        hi_d     = hi_q;
        dir_d    = dir_q;
        cy_d     = cy_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        // In IDLE the core serves the request directly; in EXEC it forms
        // the MUL partial sum hi + (multiplier bit ? A : 0).
        core_op_s = SELECT;
        core_a_s  = DATA1;
        core_b_s  = DATA2;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    case (SELECT)
                        OP_MUL: begin
                            state_d = ST_EXEC;
                            cnt_d   = CNT_MUL;
                            op_d    = SELECT;
                            a_d     = DATA1;
                            sr_d    = DATA2;
                            hi_d    = {WIDTH{1'b0}};
                        end
                        OP_SHIFT, OP_ROR: begin
                            if (DATA2[SHW-1:0] != {SHW{1'b0}}) begin
                                state_d = ST_EXEC;
                                cnt_d   = {1'b0, DATA2[SHW-1:0]};
                                op_d    = SELECT;
                                sr_d    = DATA1;
                                dir_d   = DATA2[WIDTH-1];
                                cy_d    = 1'b0;
                            end else begin
                                // Zero amount: A passes through, nothing shifted out.
                                result_d = DATA1;
                                carry_d  = 1'b0;
                                zero_d   = (DATA1 == {WIDTH{1'b0}});
                                done_d   = 1'b1;
                            end
                        end
                        default: begin
                            result_d = core_res_s;
                            carry_d  = core_cy_s;
                            zero_d   = (core_res_s == {WIDTH{1'b0}});
                            done_d   = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EXEC: begin
                core_op_s = OP_ADD;
                core_a_s  = hi_q;
                core_b_s  = sr_q[0] ? a_q : {WIDTH{1'b0}};
                cnt_d     = cnt_q - CNT_ONE;
                case (op_q)
                    OP_MUL: begin
                        // Shift {carry, sum, low} right by one.
                        hi_d = {core_cy_s, core_res_s[WIDTH-1:1]};
                        sr_d = {core_res_s[0], sr_q[WIDTH-1:1]};
                    end
                    OP_SHIFT: begin
                        if (dir_q) begin
                            sr_d = {1'b0, sr_q[WIDTH-1:1]};
                            cy_d = sr_q[0];
                        end else begin
                            sr_d = {sr_q[WIDTH-2:0], 1'b0};
                            cy_d = sr_q[WIDTH-1];
                        end
                    end
                    OP_ROR: begin
                        sr_d = {sr_q[0], sr_q[WIDTH-1:1]};
                        cy_d = sr_q[0];
                    end
                    default: begin
                        sr_d = sr_q;
                    end
                endcase

                if (cnt_q == CNT_ONE) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    result_d = sr_d;
                    if (op_q == OP_MUL) begin
                        carry_d = (hi_d != {WIDTH{1'b0}});
                    end else begin
                        carry_d = cy_d;
                    end
                    zero_d = (sr_d == {WIDTH{1'b0}});
                end else begin
                    busy_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any op in flight.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {(SHW+1){1'b0}};
            op_q     <= OP_FWD;
            a_q      <= {WIDTH{1'b0}};
            sr_q     <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            dir_q    <= 1'b0;
            cy_q     <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            sr_q     <= sr_d;
            hi_q     <= hi_d;
            dir_q    <= dir_d;
            cy_q     <= cy_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign RESULT = result_q;
    assign ZERO   = zero_q;
    assign CARRY  = carry_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed self-checking bench for alu_multicycle (WIDTH=8).
// Expected results come from a behavioural model and are queued when a
// request is driven, then popped when DONE is seen.
module tb_alu_multicycle;
    import alu_pkg::*;

    logic       CLK;
    logic       RESETN;
    logic       START;
    logic [2:0] SELECT;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [7:0] RESULT;
    logic       ZERO;
    logic       CARRY;
    logic       BUSY;
    logic       DONE;

    typedef struct {
        logic [7:0] r;
        logic       z;
        logic       c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_multicycle #(.WIDTH(8)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .START  (START),
        .SELECT (SELECT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .RESULT (RESULT),
        .ZERO   (ZERO),
        .CARRY  (CARRY),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Behavioural reference: {result[7:0], zero, carry}.
    function automatic logic [9:0] model(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [7:0]  r;
        logic        c;
        int          k;
        k = int'(b[2:0]);
        r = 8'h00;
        c = 1'b0;
        case (sel)
            OP_FWD: r = b;
            OP_ADD: {c, r} = a + b;
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_SUB: begin
                r = a - b;
                c = (a >= b);
            end
            OP_MUL: begin
                p = a * b;
                r = p[7:0];
                c = (p[15:8] != 8'h00);
            end
            OP_SHIFT: begin
                if (k == 0) begin
                    r = a;
                end else if (!b[7]) begin
                    r = a << k;
                    c = a[8-k];
                end else begin
                    r = a >> k;
                    c = a[k-1];
                end
            end
            default: begin
                if (k == 0) begin
                    r = a;
                end else begin
                    r = (a >> k) | (a << (8 - k));
                    c = r[7];
                end
            end
        endcase
        return {r, (r == 8'h00), c};
    endfunction

    function automatic int latency(input logic [2:0] sel, input logic [7:0] b);
        if (sel == OP_MUL) return 8;
        if (sel == OP_SHIFT || sel == OP_ROR) return int'(b[2:0]);
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        logic [9:0] m;
        exp_t       e;
        m   = model(sel, a, b);
        e.r = m[9:2];
        e.z = m[1];
        e.c = m[0];
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_result"}, 32'(RESULT), 32'(e.r));
            check({tag, "_zero"},   32'(ZERO),   32'(e.z));
            check({tag, "_carry"},  32'(CARRY),  32'(e.c));
        end
    endtask

    // One request; measures DONE latency and BUSY cycles, optionally pokes
    // an ADD request while the op is iterating.
    task automatic run_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b,
                          input bit inject, input string tag);
        int n;
        int cyc;
        int busy_cnt;
        logic [7:0] held;
        n = latency(sel, b);
        @(negedge CLK);
        START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
        push_exp(sel, a, b);
        @(negedge CLK);
        START = 1'b0; SELECT = 3'($urandom); DATA1 = 8'($urandom); DATA2 = 8'($urandom);
        cyc = 0;
        busy_cnt = 0;
        while (DONE !== 1'b1 && cyc < 40) begin
            if (BUSY === 1'b1) busy_cnt++;
            if (inject && cyc == 2) begin
                START = 1'b1; SELECT = OP_ADD;
            end else begin
                START = 1'b0;
            end
            @(negedge CLK);
            cyc++;
        end
        START = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(n));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'((n > 0) ? n - 1 : 0));
        check({tag, "_busy_in_done"}, 32'(BUSY), 32'd0);
        held = RESULT;
        pop_check(tag);
        @(negedge CLK);
        check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
        check({tag, "_hold"}, 32'(RESULT), 32'(held));
    endtask

    initial begin
        RESETN = 1'b0;
        START  = 1'b0;
        SELECT = 3'b000;
        DATA1  = 8'h00;
        DATA2  = 8'h00;
        #12;
        check("reset_outputs", 32'({RESULT, ZERO, CARRY, BUSY, DONE}), 32'd0);
        @(negedge CLK);
        RESETN = 1'b1;

        run_op(OP_ADD,   8'h8F, 8'h09, 1'b0, "add");
        run_op(OP_SUB,   8'h05, 8'h05, 1'b0, "sub_eq");
        run_op(OP_SUB,   8'h03, 8'h05, 1'b0, "sub_borrow");
        run_op(OP_MUL,   8'h12, 8'h10, 1'b1, "mul_inject");
        run_op(OP_SHIFT, 8'h81, 8'h03, 1'b0, "shl3");
        run_op(OP_SHIFT, 8'h81, 8'h81, 1'b0, "shr1");
        run_op(OP_ROR,   8'h01, 8'h01, 1'b0, "ror1");
        run_op(OP_ROR,   8'hB4, 8'h07, 1'b0, "ror7");
        run_op(OP_SHIFT, 8'hA5, 8'h80, 1'b0, "shift_k0");
        run_op(OP_MUL,   8'h0F, 8'h0D, 1'b0, "mul_small");
        for (int i = 0; i < 6; i++) begin
            run_op(3'($urandom), 8'($urandom), 8'($urandom), 1'b0, "rand");
        end

        // Back-to-back single-cycle ops with START held high.
        @(negedge CLK);
        START = 1'b1; SELECT = OP_FWD; DATA1 = 8'hAA; DATA2 = 8'h55;
        push_exp(OP_FWD, 8'hAA, 8'h55);
        @(negedge CLK);
        check("b2b_fwd_done", 32'(DONE), 32'd1);
        pop_check("b2b_fwd");
        SELECT = OP_AND; DATA1 = 8'h0F; DATA2 = 8'h3C;
        push_exp(OP_AND, 8'h0F, 8'h3C);
        @(negedge CLK);
        check("b2b_and_done", 32'(DONE), 32'd1);
        pop_check("b2b_and");
        SELECT = OP_OR; DATA1 = 8'h0F; DATA2 = 8'h30;
        push_exp(OP_OR, 8'h0F, 8'h30);
        @(negedge CLK);
        START = 1'b0;
        check("b2b_or_done", 32'(DONE), 32'd1);
        pop_check("b2b_or");
        @(negedge CLK);
        check("b2b_idle_done", 32'(DONE), 32'd0);

        // MUL aborted by reset at edge E0+4; no result is expected from it.
        @(negedge CLK);
        START = 1'b1; SELECT = OP_MUL; DATA1 = 8'hFF; DATA2 = 8'hFF;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        check("abort_busy_before", 32'(BUSY), 32'd1);
        repeat (3) @(posedge CLK);
        #1 RESETN = 1'b0;
        #1;
        check("abort_async_reset", 32'({RESULT, ZERO, CARRY, BUSY, DONE}), 32'd0);
        @(negedge CLK);
        RESETN = 1'b1;
        run_op(OP_ADD, 8'h01, 8'h01, 1'b0, "after_reset_add");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Parametrised multi-cycle ALU that replaces the single-cycle 8-bit ALU in the processor datapath.
- Keeps the FORWARD/ADD/AND/OR encodings.
- Adds SUB, an iterative shift-add MUL, logical shift and rotate.
- Adds ZERO/CARRY flags and a START/BUSY/DONE handshake, so the control unit can stall the PC while an iterative op runs.

Parameters:
WIDTH, 8, operand/result width in bits; power of two, >= 4.
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
CLK  input  1  system clock, rising-edge.
RESETN  input  1  asynchronous, active-low reset.
START  input  1  request; sampled only when BUSY=0.
SELECT  input  3  opcode, captured with START.
DATA1  input  WIDTH  operand A (shift/rotate source), captured with START.
DATA2  input  WIDTH  operand B; for shifts, [SHW-1:0] = amount and [WIDTH-1] = direction. Captured with START.
RESULT  output  WIDTH  registered result; holds until the next completion.
ZERO  output  1  registered; RESULT == 0.
CARRY  output  1  registered; meaning depends on opcode.
BUSY  output  1  iterative op in progress.
DONE  output  1  one-cycle pulse; RESULT/ZERO/CARRY updated this cycle.

Behaviour:
- Reset (RESETN low, async, any state including mid-op): FSM goes to IDLE. RESULT=0, ZERO=0, CARRY=0, BUSY=0, DONE=0. The partial op is discarded.
- FSM states are IDLE and EXEC. There is no separate done state; DONE is a registered pulse asserted while the FSM is in IDLE.
- Timing convention: START is sampled at edge E0. DONE is high in the cycle after edge E0+N. BUSY is high in cycles strictly between E0 and E0+N, and is low in the DONE cycle.
- Opcodes and N:
  - 000 FORWARD: RESULT=B, CARRY=0, N=0.
  - 001 ADD: RESULT=A+B mod 2^WIDTH, CARRY=carry-out, N=0.
  - 010 AND: CARRY=0, N=0.
  - 011 OR: CARRY=0, N=0.
  - 100 SUB: RESULT=A-B mod 2^WIDTH, CARRY=1 iff A>=B unsigned (no borrow), N=0.
  - 101 MUL: unsigned shift-add, one multiplier bit per cycle. RESULT = low WIDTH bits of A*B. CARRY=1 iff the high WIDTH bits are nonzero. N=WIDTH.
  - 110 SHIFT: B[WIDTH-1]=0 → logical left; =1 → logical right. Amount k=B[SHW-1:0], one bit per cycle, N=k. CARRY = last bit shifted out; 0 if k=0.
  - 111 ROR: rotate A right by k, N=k. CARRY = final RESULT[WIDTH-1] when k>0, else 0.
- N=0 ops complete directly from IDLE and never enter EXEC.
- ZERO is updated on every completion from the new RESULT.
- START while BUSY=1 is ignored, with no side effect. Operand changes during EXEC have no effect because operands are captured at E0.
- START may be high in the DONE cycle and is accepted, so back-to-back N=0 ops give one result per cycle.
- Without START, RESULT/ZERO/CARRY hold and DONE=0.
- Iteration counter width is SHW+1, so MUL can count WIDTH iterations.

Decomposition:
- Package alu_pkg: opcode localparams (OP_FWD..OP_ROR) and the state encoding (ST_IDLE, ST_EXEC).
- Sub-module alu_comb_core (WIDTH): purely combinational FORWARD/ADD/SUB/AND/OR with carry-out. Used for N=0 ops and for the MUL partial-sum add.
- The FSM, counter, shift/rotate register and MUL accumulator live in alu_multicycle.

Test Plan:
- WIDTH=8. ADD A=0x8F, B=0x09 → DONE the cycle after the START edge, RESULT=0x98, CARRY=0, ZERO=0, BUSY never high.
- SUB A=0x05, B=0x05 → RESULT=0x00, ZERO=1, CARRY=1. Then SUB A=0x03, B=0x05 → RESULT=0xFE, CARRY=0.
- MUL A=0x12, B=0x10 → BUSY high 7 cycles, DONE after edge E0+8, RESULT=0x20, CARRY=1 (product 0x120). During EXEC, START with ADD is ignored.
- SHIFT A=0x81, B=0x03 (left 3) → DONE after E0+3, RESULT=0x08, CARRY=0. Then B=0x81 (right 1) → RESULT=0x40, CARRY=1. ROR A=0x01, B=0x01 → RESULT=0x80, CARRY=1.
- Back-to-back: START held high for FWD 0x55, AND 0x0F&0x3C, OR 0x0F|0x30 → DONE high 3 consecutive cycles with RESULT 0x55, 0x0C, 0x3F.
- MUL 0xFF*0xFF with RESETN pulsed low mid-EXEC (edge E0+4) → outputs 0 immediately (asynchronously), FSM in IDLE, next ADD 0x01+0x01 → RESULT=0x02 with normal latency.
